four_bit_and_serializer: RTL
============================

Name: four_bit_and_serializer

Overview:
- Parallel-to-serial counterpart of the team's 4-input AND cascade.
- Accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per accepted beat, LSB first (bit 0 = first operand "a").
- Alongside each bit it emits the running AND of all bits emitted so far, reproducing the cascade partials (a&b, then &c, then &d) over time.
- After the last bit it pulses a final all-ones result. Sits between a parallel register source and a serial consumer.

Parameters:
- WIDTH, 4, bits per word (legal range 2..16).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  source presents in_data.
- in_ready  output  1  block can accept a word.
- in_data  input  WIDTH  word to serialize; bit 0 goes out first.
- out_valid  output  1  out_bit/out_and/out_last are valid.
- out_ready  input  1  consumer accepts the current beat.
- out_bit  output  1  current serial bit.
- out_and  output  1  AND of all bits of this word up to and including out_bit.
- out_last  output  1  current beat is bit WIDTH-1.
- result_valid  output  1  one-cycle pulse: word finished.
- result  output  1  AND of all WIDTH bits; held until the next word finishes.

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous, active-low.
- Reset values:
  - state=IDLE, shreg=0, cnt=0, run_and=1, result=0.
  - Outputs: in_ready=1, out_valid=0, out_bit=0, out_and=0, out_last=0, result_valid=0, result=0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: shreg<=in_data, cnt<=0, run_and<=1, go SHIFT.
- SHIFT:
  - in_ready=0, out_valid=1.
  - Combinational from registers: out_bit=shreg[0]; out_and=run_and&shreg[0]; out_last=(cnt==WIDTH-1).
  - Beat accepted when out_valid&&out_ready:
    - run_and<=out_and, shreg<=shreg>>1, cnt<=cnt+1.
    - If out_last: result<=out_and, go DONE.
  - out_ready=0: all registers hold, so outputs stay stable (no bit dropped or repeated).
- DONE:
  - result_valid=1 for exactly one cycle; in_ready=0, out_valid=0.
  - Go IDLE unconditionally.
- Outside SHIFT, out_bit/out_and/out_last are forced to 0.
- Latency (out_ready held high, word accepted at edge k):
  - Bits valid in cycles k+1..k+WIDTH.
  - result_valid in cycle k+WIDTH+1.
  - in_ready high again in cycle k+WIDTH+2.
  - Throughput: one word per WIDTH+2 cycles.
- Boundaries:
  - in_valid outside IDLE is ignored and the word is not captured; the source must hold it until in_ready.
  - Once out_and is 0 it stays 0 for the rest of the word.
  - result is not cleared at word start; it changes only on entry to DONE.
  - reset_n low mid-SHIFT aborts immediately to reset values, with no result_valid and no partial result update.
  - cnt width is $clog2(WIDTH); it never exceeds WIDTH-1 in SHIFT.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and the default WIDTH constant.
- One natural sub-module, and_accumulator_reg: holds run_and and result, with load/step/finish controls. All other logic stays flat.

Test Plan:
- Reset, then in_data=4'b1111 with out_ready=1:
  - out_bit=1,1,1,1; out_and=1,1,1,1; out_last only on beat 4.
  - result_valid pulses once with result=1, at cycle 5 after accept.
- in_data=4'b1011 (LSB first: 1,1,0,1):
  - out_and=1,1,0,0.
  - result=0; result_valid pulses once.
- Backpressure: word 4'b0111, out_ready=0 for 3 cycles on beat 2:
  - out_bit=1 and out_and=1 held stable for those cycles.
  - Sequence resumes 1,1,1,0 / 1,1,1,0; result=0.
- in_valid held high with a different word during SHIFT:
  - in_ready=0, second word is not captured.
  - It is captured in the cycle after DONE; the first word's output is unchanged.
- reset_n pulsed low during beat 3 of 4'b1111:
  - All outputs take reset values asynchronously; no result_valid; result stays 0.
- Back-to-back 4'b1111 then 4'b1110 with in_valid always high:
  - results 1 then 0.
  - Second accept occurs exactly WIDTH+2=6 cycles after the first.

Source files
------------

// File: rtl/four_bit_and_serializer_pkg.sv
// Shared definitions for the AND-cascade serializer: FSM encoding and default word width.
package four_bit_and_serializer_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/and_accumulator_reg.sv
// Running-AND accumulator: tracks the AND of bits emitted so far and latches the word result.
module and_accumulator_reg (
  input  logic clk,
  input  logic reset_n,
  input  logic load_i,    // start of word: running AND back to identity
  input  logic step_i,    // beat accepted: fold bit_i into running AND
  input  logic finish_i,  // last beat accepted: capture final AND
  input  logic bit_i,
  output logic out_and_o,
  output logic result_o
);

  logic run_and_q;
  logic result_q;

  assign out_and_o = run_and_q & bit_i;
  assign result_o  = result_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_and_q <= 1'b1;
      result_q  <= 1'b0;
    end else begin
      if (load_i) begin
        run_and_q <= 1'b1;
      end else if (step_i) begin
        run_and_q <= out_and_o;
      end
      if (finish_i) begin
        result_q <= out_and_o;
      end
    end
  end

endmodule

// File: rtl/four_bit_and_serializer.sv
// Serializes a WIDTH-bit word LSB first with a running AND per beat, then pulses the final AND.
module four_bit_and_serializer
  import four_bit_and_serializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_bit,
  output logic             out_and,
  output logic             out_last,
  output logic             result_valid,
  output logic             result
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  logic acc_load, acc_step, acc_finish;
  logic acc_out_and;
  logic in_shift;
  logic is_last;

  assign in_shift = (state_q == SHIFT);
  assign is_last  = (cnt_q == LAST_IDX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    result_valid = 1'b0;
    acc_load     = 1'b0;
    acc_step     = 1'b0;
    acc_finish   = 1'b0;

    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          shreg_d  = in_data;
          cnt_d    = '0;
          acc_load = 1'b1;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          shreg_d  = shreg_q >> 1;
          acc_step = 1'b1;
          if (is_last) begin
            cnt_d      = '0;
            acc_finish = 1'b1;
            state_d    = DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DONE: begin
        result_valid = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  and_accumulator_reg u_acc (
    .clk       (clk),
    .reset_n   (reset_n),
    .load_i    (acc_load),
    .step_i    (acc_step),
    .finish_i  (acc_finish),
    .bit_i     (shreg_q[0]),
    .out_and_o (acc_out_and),
    .result_o  (result)
  );

  // Beat outputs are gated so nothing stale leaks out while idle or finishing.
  assign out_bit  = in_shift & shreg_q[0];
  assign out_and  = in_shift & acc_out_and;
  assign out_last = in_shift & is_last;

endmodule
